// File: rtl/mul_sequencer.sv
// Control sequencer for a shift-and-add multiplier.
// Walks the multiplier one bit at a time through LOAD -> (TEST [-> ADD] -> SHIFT) x WIDTH -> DONE
// and issues the datapath strobes. Every output is a registered decode of the state being
// entered, so each output is a pure Moore function of the current state and bit counter.
// Requires 2**CNT_W >= WIDTH and WIDTH in 2..16.
// Optional build macro MUL_EARLY_EXIT_EN: TEST finishes the operation as soon as the
// remaining multiplier bits are all zero (md_zero), ahead of testing md_lsb.

module mul_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             md_lsb,
    input  logic             md_zero,
    output logic             ld_op,
    output logic             clr_acc,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StTest,
        StAdd,
        StShift,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_op_q, ld_op_d;
    logic             clr_acc_q, clr_acc_d;
    logic             add_en_q, add_en_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifndef MUL_EARLY_EXIT_EN
    // md_zero only matters when early termination is built in.
    logic unused_md_zero;
    assign unused_md_zero = md_zero;
`endif

    // Next-state, bit counter and output decode of the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                state_d = StTest;
                cnt_d   = '0;
            end
            StTest: begin
`ifdef MUL_EARLY_EXIT_EN
                if (md_zero) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else if (md_lsb) begin
                    state_d = StAdd;
                end else begin
                    state_d = StShift;
                end
`else
                if (md_lsb) begin
                    state_d = StAdd;
                end else begin
                    state_d = StShift;
                end
`endif
            end
            StAdd: begin
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    state_d = StTest;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Strobes follow the state being entered so they line up with it after the edge.
        ld_op_d    = (state_d == StLoad);
        clr_acc_d  = (state_d == StLoad);
        add_en_d   = (state_d == StAdd);
        shift_en_d = (state_d == StShift);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    // State, counter and registered outputs; reset aborts any operation immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ld_op_q    <= 1'b0;
            clr_acc_q  <= 1'b0;
            add_en_q   <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_op_q    <= ld_op_d;
            clr_acc_q  <= clr_acc_d;
            add_en_q   <= add_en_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ld_op    = ld_op_q;
    assign clr_acc  = clr_acc_q;
    assign add_en   = add_en_q;
    assign shift_en = shift_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: a behavioural datapath closes the loop, a driver issues
// operations and pushes predicted results into a queue, and a monitor pops them on done.
module tb_mul_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          md_lsb;
    logic          md_zero;
    logic          ld_op, clr_acc, add_en, shift_en, busy, done;
    logic [CW-1:0] bit_cnt;

    always #5 clock = ~clock;

    mul_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .md_lsb   (md_lsb),
        .md_zero  (md_zero),
        .ld_op    (ld_op),
        .clr_acc  (clr_acc),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .bit_cnt  (bit_cnt)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned issued = 0;
    int unsigned aborted = 0;
    int unsigned loads = 0;
    int unsigned dones = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural datapath driven by the strobes.
    logic [2*W-1:0] mc, acc;
    logic [W-1:0]   mp;
    logic [W-1:0]   op_a = '0, op_b = '0;

    always @(posedge clock) begin
        if (ld_op) begin
            mc <= {{W{1'b0}}, op_a};
            mp <= op_b;
        end
        if (clr_acc) acc <= '0;
        if (add_en) acc <= acc + mc;
        if (shift_en) begin
            mc <= mc << 1;
            mp <= mp >> 1;
        end
    end

    assign md_lsb  = mp[0];
    assign md_zero = (mp == '0);

    // Reference model: result and timing from bit counts of the multiplier.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int unsigned  done_cyc;
        int unsigned  adds;
        int unsigned  shifts;
    } exp_t;

    exp_t q[$];

    function automatic exp_t predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input int unsigned e);
        exp_t        x;
        int unsigned n;
        int unsigned len;
        n   = $countones(b);
        len = 0;
        for (int i = 0; i < W; i++) if (b[i]) len = i + 1;
        x.a    = a;
        x.b    = b;
        x.adds = n;
`ifdef MUL_EARLY_EXIT_EN
        if (len < W) begin
            x.done_cyc = e + 3 + 2 * len + n;
            x.shifts   = len;
        end else begin
            x.done_cyc = e + 2 + 2 * W + n;
            x.shifts   = W;
        end
`else
        x.done_cyc = e + 2 + 2 * W + n;
        x.shifts   = W;
`endif
        return x;
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on done.
    int unsigned n_add = 0;
    int unsigned n_shift = 0;
    bit          in_op = 1'b0;

    always @(negedge clock) begin
        if (resetn) begin
            check("strobe_onehot", 32'($countones({ld_op, add_en, shift_en}) <= 1), 32'd1);
            check("bit_cnt_range", 32'(bit_cnt <= CW'(W - 1)), 32'd1);
            if (ld_op) begin
                loads++;
                in_op   = 1'b1;
                n_add   = 0;
                n_shift = 0;
            end
            check("busy", 32'(busy), 32'(in_op));
            if (add_en) n_add++;
            if (shift_en) begin
                check("bit_cnt_at_shift", 32'(bit_cnt), n_shift);
                n_shift++;
            end
            if (done) begin
                dones++;
                in_op = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with no operation pending (cycle %0d)",
                             cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("product", 32'(acc), 32'(e.a) * 32'(e.b));
                    check("done_cycle", cyc, e.done_cyc);
                    check("add_count", n_add, e.adds);
                    check("shift_count", n_shift, e.shifts);
                end
            end
        end else begin
            in_op = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ld_op"}, 32'(ld_op), 32'd0);
        check({tag, "_clr_acc"}, 32'(clr_acc), 32'd0);
        check({tag, "_add_en"}, 32'(add_en), 32'd0);
        check({tag, "_shift_en"}, 32'(shift_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bit_cnt"}, 32'(bit_cnt), 32'd0);
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (ld_op) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 32'(ok), 32'd1);
    endtask

    // Issue n operations; hold keeps start high for back-to-back runs, pulse_at (>0) pulses
    // start at that cycle of the first operation, where it must be ignored.
    task automatic do_ops(input int n, input bit hold, input int unsigned pulse_at,
                          input bit dir, input logic [W-1:0] da, input logic [W-1:0] db);
        int unsigned e;
        bit          ok;
        exp_t        x;
        @(negedge clock);
        #1;
        e     = cyc;
        start = 1'b1;
        for (int k = 0; k < n; k++) begin
            op_a = dir ? da : W'($urandom);
            op_b = dir ? db : W'($urandom);
            x    = predict(op_a, op_b, e);
            q.push_back(x);
            issued++;
            wait_load(ok);
            check("load_cycle", ok ? cyc : 32'hFFFF_FFFF, e + 1);
            if (!hold || k == n - 1) start = 1'b0;
            if (pulse_at > 0 && k == 0) begin
                while (cyc < e + pulse_at) @(negedge clock);
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end else begin
                @(posedge clock);
                #1;
            end
            e = x.done_cyc + 1;
        end
        wait_drain();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        bit ok;
        #12;
        check_all_zero("reset");
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);

        do_ops(1, 1'b0, 0, 1'b1, 8'h5A, 8'h00);
        do_ops(1, 1'b0, 0, 1'b1, 8'h03, 8'hFF);
        do_ops(1, 1'b0, 0, 1'b1, 8'h07, 8'h05);
        do_ops(1, 1'b0, 0, 1'b1, 8'h11, 8'h80);
        do_ops(1, 1'b0, 5, 1'b1, 8'hC3, 8'h6B);
        do_ops(3, 1'b1, 0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) do_ops(1, 1'b0, 0, 1'b0, 8'h00, 8'h00);

        // Abort mid-ADD with reset.
        @(negedge clock);
        op_a  = 8'h03;
        op_b  = 8'hFF;
        q.push_back(predict(op_a, op_b, cyc));
        issued++;
        start = 1'b1;
        wait_load(ok);
        start = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (add_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("saw_add_before_reset", 32'(ok), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("abort");
        q.delete();
        aborted++;
        start = 1'b1;
        repeat (3) @(negedge clock);
        start  = 1'b0;
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        check("post_reset_idle", 32'(busy), 32'd0);

        do_ops(1, 1'b0, 0, 1'b1, 8'hFF, 8'hFF);
        do_ops(2, 1'b1, 0, 1'b0, 8'h00, 8'h00);

        check("load_count", loads, issued);
        check("done_count", dones, issued - aborted);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
